// File: rtl/wr_data_send_channel.sv
`default_nettype none
//------------------------------------------------------------------------------
// wr_data_send_channel : AXI write-data sender fed by a burst-length FIFO
// Rev 1.0 | optional macro STALL_CNT_EN adds the stall_cycles counter
//------------------------------------------------------------------------------
module wr_data_send_channel #(
  parameter int DATA_WIDTH  = 1024,
  parameter int LEN_FIFO_AW = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    engine_start,
  input  logic [39:0]             total_beat_count,
  input  logic [31:0]             pattern_seed,
  input  logic                    burst_push,
  input  logic [7:0]              burst_len,
  output logic                    len_fifo_full,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  output logic                    data_send_done,
  output logic                    data_error
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  localparam int                  DEPTH    = 1 << LEN_FIFO_AW;
  localparam int                  LANES    = DATA_WIDTH / 32;
  localparam logic [31:0]         LANES_C  = 32'(LANES);
  localparam logic [LEN_FIFO_AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [7:0]             r_len_mem [DEPTH];
  logic [LEN_FIFO_AW:0]   r_wr_ptr, r_rd_ptr, w_occ;
  logic [7:0]             r_beat;
  logic [39:0]            r_total_sent, r_total;
  logic [31:0]            r_seed;
  logic                   r_error;
  logic                   w_empty, w_full, w_valid, w_last, w_hs, w_pop;
  logic                   w_push_req, w_push, w_err_set;
  logic [7:0]             w_head;
  logic [31:0]            w_base;

  // Pointers carry one extra bit so a full FIFO is distinguishable from empty.
  assign w_occ   = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_occ == '0);
  assign w_full  = w_occ[LEN_FIFO_AW];
  assign w_head  = r_len_mem[r_rd_ptr[LEN_FIFO_AW-1:0]];

  assign w_valid    = (r_state == ST_SEND) && !w_empty && !r_error;
  assign w_last     = w_valid && (r_beat == w_head);
  assign w_hs       = w_valid && axi_wready;
  assign w_pop      = w_hs && w_last;
  assign w_push_req = burst_push && !r_error &&
                      ((r_state == ST_SEND) || (r_state == ST_DONE));
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_err_set  = (w_push_req && w_full && !w_pop) ||
                      (w_hs && (r_total_sent == r_total)) ||
                      (w_pop && (r_total_sent >= r_total));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (engine_start) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = (r_total == '0) ? ST_DONE : ST_SEND;
      ST_SEND: begin
        if (r_error)                        w_state_nxt = ST_IDLE;
        else if (r_total_sent == r_total)   w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_beat       <= '0;
      r_total_sent <= '0;
      r_total      <= '0;
      r_seed       <= '0;
      r_error      <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && engine_start) begin
        r_total <= total_beat_count;
        r_seed  <= pattern_seed;
      end
      if (engine_start)   r_error <= 1'b0;
      else if (w_err_set) r_error <= 1'b1;
      if (r_state == ST_LOAD) begin
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_beat       <= '0;
        r_total_sent <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        if (w_hs) begin
          r_total_sent <= r_total_sent + 40'd1;
          r_beat       <= w_last ? 8'd0 : r_beat + 8'd1;
        end
      end
    end
  end

  // Storage needs no reset: entries are only read once the pointers cover them.
  always_ff @(posedge clk) begin
    if (w_push) r_len_mem[r_wr_ptr[LEN_FIFO_AW-1:0]] <= burst_len;
  end

  assign w_base = r_seed + r_total_sent[31:0] * LANES_C;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign axi_wdata[gi*32 +: 32] = w_valid ? (w_base + 32'(gi)) : 32'd0;
    end
  endgenerate

  assign axi_wstrb      = {(DATA_WIDTH/8){w_valid}};
  assign axi_wvalid     = w_valid;
  assign axi_wlast      = w_last;
  assign len_fifo_full  = w_full;
  assign data_send_done = (r_state == ST_DONE);
  assign data_error     = r_error;

`ifdef STALL_CNT_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         r_stall <= '0;
    else if (r_state == ST_LOAD)                        r_stall <= '0;
    else if (w_valid && !axi_wready && (r_stall != '1)) r_stall <= r_stall + 32'd1;
  end

  assign stall_cycles = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wr_data_send_channel.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// tb_wr_data_send_channel : directed bench with a queue-based reference model
// Rev 1.0
//------------------------------------------------------------------------------
module tb_wr_data_send_channel;
  localparam int DW    = 1024;
  localparam int AW    = 4;
  localparam int LANES = DW / 32;
  localparam int P_IDLE = 0, P_LOAD = 1, P_SEND = 2, P_DONE = 3;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          engine_start = 1'b0, burst_push = 1'b0, axi_wready = 1'b0;
  logic [39:0]   total_beat_count = '0;
  logic [31:0]   pattern_seed = '0;
  logic [7:0]    burst_len = '0;
  logic          len_fifo_full, axi_wlast, axi_wvalid, data_send_done, data_error;
  logic [DW-1:0] axi_wdata;
  logic [DW/8-1:0] axi_wstrb;
`ifdef STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  wr_data_send_channel #(.DATA_WIDTH(DW), .LEN_FIFO_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .engine_start(engine_start),
    .total_beat_count(total_beat_count), .pattern_seed(pattern_seed),
    .burst_push(burst_push), .burst_len(burst_len), .len_fifo_full(len_fifo_full),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .data_send_done(data_send_done), .data_error(data_error)
`ifdef STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a length queue plus counters, advanced once per clock.
  int          m_phase;
  int unsigned m_q[$];
  int unsigned m_beat;
  longint      m_sent, m_total;
  logic [31:0] m_seed, m_stall;
  bit          m_err;

  int vectors = 0, miscompares = 0;
  int obs_hs, obs_done, obs_done_cyc, obs_valid, cyc_idx;
  logic [63:0] obs_lastmask;
  logic [31:0] obs_lane0 [64];

  function automatic bit f_valid();
    return (m_phase == P_SEND) && (m_q.size() != 0) && !m_err;
  endfunction

  function automatic bit f_last();
    if (!f_valid()) return 1'b0;
    return m_beat == m_q[0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_q.delete(); m_beat = 0; m_sent = 0; m_total = 0;
    m_seed = '0; m_err = 1'b0; m_stall = '0;
  endtask

  task automatic clear_obs();
    obs_hs = 0; obs_done = 0; obs_done_cyc = -1; obs_valid = 0; cyc_idx = 0;
    obs_lastmask = '0;
  endtask

  task automatic compare();
    bit ev;
    logic [DW/8-1:0] es;
    int bad_lane;
    logic [31:0] lexp;
    ev = f_valid();
    es = ev ? '1 : '0;
    chk("wvalid", axi_wvalid, ev);
    chk("wlast", axi_wlast, f_last());
    chk("done", data_send_done, m_phase == P_DONE);
    chk("error", data_error, m_err);
    chk("full", len_fifo_full, m_q.size() == 16);
    vectors++;
    if (axi_wstrb !== es) begin
      miscompares++;
      $display("FAIL wstrb: got %h expected %h", axi_wstrb, es);
    end
    bad_lane = -1;
    for (int i = 0; i < LANES; i++) begin
      lexp = ev ? (m_seed + 32'(m_sent) * 32'(LANES) + 32'(i)) : 32'd0;
      if (bad_lane < 0 && axi_wdata[i*32 +: 32] !== lexp) begin
        bad_lane = i;
        vectors++;
        miscompares++;
        $display("FAIL wdata lane %0d: got %h expected %h", i, axi_wdata[i*32 +: 32], lexp);
      end
    end
    if (bad_lane < 0) vectors++;
`ifdef STALL_CNT_EN
    chk("stall_cycles", stall_cycles, m_stall);
`endif
    if (axi_wvalid && axi_wready) begin
      obs_hs++;
      if (obs_hs < 64) begin
        obs_lane0[obs_hs] = axi_wdata[31:0];
        if (axi_wlast) obs_lastmask[obs_hs] = 1'b1;
      end
    end
    if (axi_wvalid) obs_valid++;
    if (data_send_done) begin
      obs_done++;
      if (obs_done_cyc < 0) obs_done_cyc = cyc_idx;
    end
    cyc_idx++;
  endtask

  task automatic model_step();
    bit ev, el, hs, pop, preq, nerr;
    int sz;
    longint sent0;
    ev = f_valid(); el = f_last();
    hs = ev && axi_wready; pop = hs && el;
    preq = burst_push && (m_phase == P_SEND || m_phase == P_DONE) && !m_err;
    sz = m_q.size(); sent0 = m_sent;
    nerr = m_err;
    if ((preq && sz == 16 && !pop) || (hs && m_sent == m_total) || (pop && m_sent + 1 > m_total))
      nerr = 1'b1;
    if (engine_start) nerr = 1'b0;
    if (m_phase == P_LOAD) m_stall = '0;
    else if (ev && !axi_wready && m_stall != 32'hFFFF_FFFF) m_stall++;
    case (m_phase)
      P_IDLE: if (engine_start) begin
        m_phase = P_LOAD; m_total = longint'(total_beat_count); m_seed = pattern_seed;
      end
      P_LOAD: begin
        m_q.delete(); m_beat = 0; m_sent = 0;
        m_phase = (m_total == 0) ? P_DONE : P_SEND;
      end
      default: begin
        if (pop) void'(m_q.pop_front());
        if (preq && (sz < 16 || pop)) m_q.push_back(int'(burst_len));
        if (hs) begin
          m_sent++;
          m_beat = pop ? 0 : m_beat + 1;
        end
        if (m_phase == P_DONE) m_phase = P_IDLE;
        else if (m_err) m_phase = P_IDLE;
        else if (sent0 == m_total) m_phase = P_DONE;
      end
    endcase
    m_err = nerr;
  endtask

  task automatic cyc(input bit st, input bit ps, input logic [7:0] ln, input bit rd);
    engine_start = st; burst_push = ps; burst_len = ln; axi_wready = rd;
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_start(input logic [39:0] tot, input logic [31:0] seed);
    total_beat_count = tot; pattern_seed = seed;
    clear_obs();
    cyc(1, 0, 8'd0, 0);
    cyc(0, 0, 8'd0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    clear_obs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wvalid", axi_wvalid, 0);
    chk("reset_wdata_any", |axi_wdata, 0);
    chk("reset_done", data_send_done, 0);
    chk("reset_error", data_error, 0);
    rst_n = 1'b1;

    // Single 16-beat burst
    run_start(40'd16, 32'h100);
    cyc(0, 1, 8'd15, 1);
    repeat (20) cyc(0, 0, 8'd0, 1);
    chk("t1_beats", obs_hs, 16);
    chk("t1_wlast_pos", obs_lastmask, 64'h1 << 16);
    chk("t1_lane0_first", obs_lane0[1], 32'h100);
    chk("t1_lane0_last", obs_lane0[16], 32'h2E0);
    chk("t1_done_count", obs_done, 1);
    chk("t1_done_cycle", obs_done_cyc, 20);

    // Two bursts with alternating backpressure
    run_start(40'd10, 32'h0);
    cyc(0, 1, 8'd3, 0);
    cyc(0, 1, 8'd5, 0);
    for (int i = 0; i < 40; i++) cyc(0, 0, 8'd0, (i % 2) == 0);
    chk("t2_beats", obs_hs, 10);
    chk("t2_wlast_pos", obs_lastmask, (64'h1 << 4) | (64'h1 << 10));
    chk("t2_done_count", obs_done, 1);
    chk("t2_error", data_error, 0);

    // Length FIFO full, push+pop at full, then overflow
    run_start(40'd1000, 32'h0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 8'd0, 0);
    chk("t3_full", len_fifo_full, 1);
    cyc(0, 1, 8'd0, 1);
    chk("t3_full_after_pushpop", len_fifo_full, 1);
    chk("t3_no_error", data_error, 0);
    cyc(0, 1, 8'd0, 0);
    chk("t3_overflow_error", data_error, 1);
    chk("t3_wvalid_dropped", axi_wvalid, 0);
    repeat (2) cyc(0, 0, 8'd0, 0);

    // Burst longer than the total: stops at the total, no wlast
    run_start(40'd4, 32'h5);
    cyc(0, 1, 8'd7, 1);
    repeat (4) cyc(0, 0, 8'd0, 1);
    repeat (4) cyc(0, 0, 8'd0, 0);
    chk("t4_beats", obs_hs, 4);
    chk("t4_no_wlast", obs_lastmask, 0);
    chk("t4_done_count", obs_done, 1);
    chk("t4_error", data_error, 0);

    // Extra handshake once the total is reached
    run_start(40'd5, 32'h0);
    cyc(0, 1, 8'd7, 1);
    repeat (6) cyc(0, 0, 8'd0, 1);
    chk("t4b_beats", obs_hs, 6);
    chk("t4b_error", data_error, 1);
    repeat (3) cyc(0, 0, 8'd0, 0);

    // Zero total
    run_start(40'd0, 32'h0);
    repeat (4) cyc(0, 0, 8'd0, 1);
    chk("t5_done_cycle", obs_done_cyc, 2);
    chk("t5_no_wvalid", obs_valid, 0);
    chk("t5_error_cleared", data_error, 0);

    // Reset in the middle of beat 3
    run_start(40'd8, 32'h0);
    cyc(0, 1, 8'd7, 1);
    cyc(0, 0, 8'd0, 1);
    cyc(0, 0, 8'd0, 1);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_wvalid", axi_wvalid, 0);
    chk("t6_rst_wlast", axi_wlast, 0);
    chk("t6_rst_wdata_any", |axi_wdata, 0);
    chk("t6_rst_full", len_fifo_full, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_start(40'd8, 32'h0);
    cyc(0, 1, 8'd7, 0);
    repeat (5) cyc(0, 0, 8'd0, 0);
    repeat (12) cyc(0, 0, 8'd0, 1);
    chk("t6_beats", obs_hs, 8);
    chk("t6_wlast_pos", obs_lastmask, 64'h1 << 8);
    chk("t6_done_count", obs_done, 1);
`ifdef STALL_CNT_EN
    chk("t6_stall_cycles", stall_cycles, 5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
